// File: rtl/jtframe_dual_ram_clr.sv
// Single-clock true dual-port RAM with byte lanes, defined RDW/collision rules and a clear engine.
// Read latency 1 clock; while busy writes are dropped and q0/q1 hold. Optional JTFRAME_DUAL_RAM_COLL_EN adds coll/coll_cnt.
// Backpressure: none on the user ports; busy tells the user that the clear engine owns the array.
module jtframe_dual_ram_clr #(
    parameter int            dw       = 16,
    parameter int            aw       = 10,
    parameter int            cen_rd   = 0,
    parameter int            rdw_mode = 0,
    parameter logic [dw-1:0] clr_val  = '0,
    parameter                synfile  = ""
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output logic            busy,
    input  logic            cen0,
    input  logic [aw-1:0]   addr0,
    input  logic [dw-1:0]   data0,
    input  logic [dw/8-1:0] we0,
    output logic [dw-1:0]   q0,
    input  logic            cen1,
    input  logic [aw-1:0]   addr1,
    input  logic [dw-1:0]   data1,
    input  logic [dw/8-1:0] we1,
    output logic [dw-1:0]   q1
`ifdef JTFRAME_DUAL_RAM_COLL_EN
    ,
    output logic            coll,
    output logic [7:0]      coll_cnt
`endif
);

    localparam int lanes = dw / 8;
    localparam int depth = 2 ** aw;

    typedef enum logic { IDLE = 1'b0, CLEAR = 1'b1 } state_t;

    logic [dw-1:0]    mem [depth];
    state_t           state, nxt;
    logic [aw-1:0]    clr_addr;
    logic             clr_we;
    logic [lanes-1:0] w0, w1raw, w1, ov;
    logic [dw-1:0]    m0, m1;
    logic             rd0, rd1;

    // Every reset runs a full clear before the first read, so preloaded contents are never visible.
    if (synfile != "") begin : g_synfile
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= CLEAR;
        else        state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE) clr_addr <= '0;
        else                         clr_addr <= clr_addr + 1'b1;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (clr) nxt = CLEAR;
            CLEAR:   if (&clr_addr) nxt = IDLE;
            default: nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy   = (state == CLEAR);
        clr_we = busy && rst_n;
    end

    // Port 0 wins on lanes both ports enable at the same address.
    always_comb begin
        w0    = (cen0 && !busy) ? we0 : '0;
        w1raw = (cen1 && !busy) ? we1 : '0;
        ov    = (addr0 == addr1) ? (w0 & w1raw) : '0;
        w1    = w1raw & ~ov;
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= clr_val;
        end else begin
            for (int i = 0; i < lanes; i++) begin
                if (w0[i]) mem[addr0][8*i +: 8] <= data0[8*i +: 8];
                if (w1[i]) mem[addr1][8*i +: 8] <= data1[8*i +: 8];
            end
        end
    end

    // Post-write view of each read address, used when new data is returned on read-during-write.
    always_comb begin
        m0 = mem[addr0];
        m1 = mem[addr1];
        for (int i = 0; i < lanes; i++) begin
            if (w0[i]) begin
                m0[8*i +: 8] = data0[8*i +: 8];
                if (addr1 == addr0) m1[8*i +: 8] = data0[8*i +: 8];
            end
            if (w1[i]) begin
                if (addr0 == addr1) m0[8*i +: 8] = data1[8*i +: 8];
                m1[8*i +: 8] = data1[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd0 = !busy && (cen_rd == 0 || cen0);
        rd1 = !busy && (cen_rd == 0 || cen1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            if (rd0) q0 <= (rdw_mode != 0) ? m0 : mem[addr0];
            if (rd1) q1 <= (rdw_mode != 0) ? m1 : mem[addr1];
        end
    end

`ifdef JTFRAME_DUAL_RAM_COLL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll     <= 1'b0;
            coll_cnt <= 8'd0;
        end else begin
            coll <= |ov;
            if (|ov && coll_cnt != 8'hff) coll_cnt <= coll_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jtframe_dual_ram_clr.sv
// Scoreboard bench: two instances (old-data/free-running reads and new-data/gated reads) share stimulus.
// A word-array reference model predicts every output; a monitor compares after each clock.
module tb_jtframe_dual_ram_clr;

    localparam logic [15:0] CLR = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic        cen0, cen1;
    logic [3:0]  addr0, addr1;
    logic [15:0] data0, data1;
    logic [1:0]  we0, we1;
    logic [15:0] q0a, q1a, q0b, q1b;
    logic        busy_a, busy_b;
`ifdef JTFRAME_DUAL_RAM_COLL_EN
    logic        coll_a, coll_b;
    logic [7:0]  cnt_a, cnt_b;
`endif

    always #5 clk = ~clk;

    jtframe_dual_ram_clr #(.dw(16), .aw(4), .cen_rd(0), .rdw_mode(0), .clr_val(CLR)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
        .cen0(cen0), .addr0(addr0), .data0(data0), .we0(we0), .q0(q0a),
        .cen1(cen1), .addr1(addr1), .data1(data1), .we1(we1), .q1(q1a)
`ifdef JTFRAME_DUAL_RAM_COLL_EN
        , .coll(coll_a), .coll_cnt(cnt_a)
`endif
    );

    jtframe_dual_ram_clr #(.dw(16), .aw(4), .cen_rd(1), .rdw_mode(1), .clr_val(CLR)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
        .cen0(cen0), .addr0(addr0), .data0(data0), .we0(we0), .q0(q0b),
        .cen1(cen1), .addr1(addr1), .data1(data1), .we1(we1), .q1(q1b)
`ifdef JTFRAME_DUAL_RAM_COLL_EN
        , .coll(coll_b), .coll_cnt(cnt_b)
`endif
    );

    typedef struct {
        logic [15:0] q0a, q1a, q0b, q1b;
        logic        busy;
        logic        coll;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [15:0] mem [16];
    logic        m_busy = 1'b1;
    int          m_pos  = 0;
    exp_t        m;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q0_old",  q0a, e.q0a);
                chk("q1_old",  q1a, e.q1a);
                chk("q0_new",  q0b, e.q0b);
                chk("q1_new",  q1b, e.q1b);
                chk("busy_a",  {15'd0, busy_a}, {15'd0, e.busy});
                chk("busy_b",  {15'd0, busy_b}, {15'd0, e.busy});
`ifdef JTFRAME_DUAL_RAM_COLL_EN
                chk("coll_a",  {15'd0, coll_a}, {15'd0, e.coll});
                chk("coll_b",  {15'd0, coll_b}, {15'd0, e.coll});
                chk("cnt_a",   {8'd0, cnt_a}, {8'd0, e.cnt});
                chk("cnt_b",   {8'd0, cnt_b}, {8'd0, e.cnt});
`endif
            end
        end
    end

    // One clock of stimulus; the model predicts the outputs visible after the next posedge.
    task automatic step(input logic r, input logic c,
                        input logic c0, input logic [3:0] a0, input logic [15:0] d0, input logic [1:0] e0,
                        input logic c1, input logic [3:0] a1, input logic [15:0] d1, input logic [1:0] e1);
        logic [1:0]  w0, w1, ovl;
        @(negedge clk);
        rst_n = r; clr = c;
        cen0 = c0; addr0 = a0; data0 = d0; we0 = e0;
        cen1 = c1; addr1 = a1; data1 = d1; we1 = e1;
        m.coll = 1'b0;
        if (!r) begin
            m.q0a = '0; m.q1a = '0; m.q0b = '0; m.q1b = '0;
            m_busy = 1'b1; m_pos = 0; m.cnt = '0;
        end else if (m_busy) begin
            mem[m_pos] = CLR;
            m_pos++;
            if (m_pos == 16) m_busy = 1'b0;
        end else begin
            w0  = c0 ? e0 : 2'b00;
            w1  = c1 ? e1 : 2'b00;
            ovl = (a0 == a1) ? (w0 & w1) : 2'b00;
            w1  = w1 & ~ovl;
            m.q0a = mem[a0];
            m.q1a = mem[a1];
            for (int l = 0; l < 2; l++) begin
                if (w0[l]) mem[a0][8*l +: 8] = d0[8*l +: 8];
                if (w1[l]) mem[a1][8*l +: 8] = d1[8*l +: 8];
            end
            if (c0) m.q0b = mem[a0];
            if (c1) m.q1b = mem[a1];
            m.coll = |ovl;
            if (m.coll && m.cnt != 8'hff) m.cnt = m.cnt + 8'd1;
            if (c) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end
        m.busy = m_busy;
        sb.push_back(m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 4'd0, 16'd0, 2'b00, 0, 4'd0, 16'd0, 2'b00);
    endtask

    task automatic sweep();
        for (int i = 0; i < 16; i++)
            step(1, 0, 1, 4'(i), 16'd0, 2'b00, 1, 4'(15 - i), 16'd0, 2'b00);
        idle(1);
    endtask

    initial begin
        int guard;
        m.q0a = '0; m.q1a = '0; m.q0b = '0; m.q1b = '0;
        m.busy = 1'b1; m.coll = 1'b0; m.cnt = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'hxxxx;
        rst_n = 0; clr = 0; cen0 = 0; cen1 = 0;
        addr0 = 0; addr1 = 0; data0 = 0; data1 = 0; we0 = 0; we1 = 0;

        // Reset, full clear, readback of every address
        step(0, 0, 0, 4'd0, 16'd0, 2'b00, 0, 4'd0, 16'd0, 2'b00);
        step(0, 0, 0, 4'd0, 16'd0, 2'b00, 0, 4'd0, 16'd0, 2'b00);
        idle(16);
        sweep();

        // Same-address collision with one overlapping lane
        step(1, 0, 1, 4'd3, 16'h1234, 2'b11, 1, 4'd3, 16'h00FF, 2'b01);
        step(1, 0, 1, 4'd3, 16'd0, 2'b00, 1, 4'd3, 16'd0, 2'b00);
        idle(2);

        // Byte-lane write from port 1
        step(1, 0, 1, 4'd5, 16'hFFFF, 2'b11, 0, 4'd0, 16'd0, 2'b00);
        step(1, 0, 0, 4'd0, 16'd0, 2'b00, 1, 4'd5, 16'h0000, 2'b10);
        step(1, 0, 1, 4'd5, 16'd0, 2'b00, 1, 4'd5, 16'd0, 2'b00);

        // Cross-port read-during-write, then same-port read-during-write
        step(1, 0, 1, 4'd7, 16'hBEEF, 2'b11, 1, 4'd7, 16'd0, 2'b00);
        step(1, 0, 1, 4'd7, 16'hCAFE, 2'b01, 1, 4'd7, 16'd0, 2'b00);
        step(1, 0, 1, 4'd7, 16'd0, 2'b00, 1, 4'd7, 16'd0, 2'b00);

        // Read gating by cen1 with a moving address
        step(1, 0, 1, 4'd9, 16'h5A5A, 2'b11, 1, 4'd3, 16'd0, 2'b00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'd0, 16'd0, 2'b00, 0, 4'(9 + i), 16'd0, 2'b00);
        step(1, 0, 0, 4'd0, 16'd0, 2'b00, 1, 4'd9, 16'd0, 2'b00);
        step(1, 0, 0, 4'd0, 16'd0, 2'b00, 1, 4'd5, 16'd0, 2'b00);

        // Clear request, writes while busy, reset mid-clear, full rerun
        step(1, 1, 1, 4'd2, 16'h1111, 2'b11, 1, 4'd4, 16'h2222, 2'b11);
        for (int i = 0; i < 7; i++) step(1, 1, 1, 4'(i), 16'h3333, 2'b11, 1, 4'(15 - i), 16'h4444, 2'b11);
        step(0, 0, 1, 4'd1, 16'h7777, 2'b11, 0, 4'd0, 16'd0, 2'b00);
        for (int i = 0; i < 16; i++) step(1, 1, 1, 4'(i), 16'h6666, 2'b11, 1, 4'(i), 16'h9999, 2'b10);
        sweep();

        // Randomized traffic with occasional clear and reset
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
        end
        idle(20);
        sweep();

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
